dm_access_ctrl: RTL

CPU-side initiator for the word-only data memory: sits between the M pipeline stage and the data memory. It turns the stage's load/store requests into word accesses. Loads are narrowed and sign/zero-extended. Sub-word stores are executed as a registered two-cycle read-modify-write, with a pipeline stall. Misaligned and out-of-range accesses are caught before they reach memory.

---
 rtl/dm_access_ctrl_pkg.sv | 39 +++
 rtl/dm_access_ctrl_load_extender.sv | 39 +++
 rtl/dm_access_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds op and FSM state encodings, the default data-memory limit and
// the access fault predicate used by the controller.
package dm_access_ctrl_pkg;

  // First byte address outside data memory (3072 words).
  localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_3000;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  // A request faults when it is misaligned for its width or lands at or
  // beyond the end of data memory.
  function automatic logic access_fault(input op_t op,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
    logic misaligned;
    case (op)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
    return misaligned || (addr >= limit);
  endfunction

endpackage

// File: rtl/dm_access_ctrl_load_extender.sv
// Purpose: pick the addressed byte/half lane out of a memory word and
//   sign- or zero-extend it to 32 bits (whole word for LW).
// Ports: word (memory word), lane (addr[1:0]), op (access type), data (result).
// Latency: combinational. Backpressure: none; store ops yield 0.
module load_extender
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  op_t         op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian: byte lane 0 sits in word[7:0], half lane 1 in word[31:16].
  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (op)
      OP_LW:   data = word;
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Purpose: M-stage initiator for the word-only data memory; loads are
//   narrowed/extended, SW writes directly, SH/SB run a registered
//   read-modify-write, misaligned/out-of-range requests raise sticky err.
// Latency: loads and SW 0 extra cycles; SH/SB 1 stall cycle, write
//   commits on the edge ending RMW_WR.
// Backpressure: stall is high only in the IDLE cycle accepting an SH/SB.
// Ports: clk/reset (sync, active-high); req_valid/op/addr/wdata/pc from the
//   M stage; rdata/stall/err to the pipeline; dm_addr/dm_wd/dm_pc/dm_we to
//   memory and dm_rd back from it (asynchronous read).
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  output logic        dm_we,
  input  logic [31:0] dm_rd
);

  state_t      state;
  op_t         op_e;
  logic        fault;
  logic        is_load;
  logic        is_sub_store;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Read-modify-write context captured in the stall cycle.
  logic [29:0] lat_word;
  logic [1:0]  lat_lane;
  logic        lat_is_half;
  logic [15:0] lat_wdata;
  logic [31:0] lat_pc;
  logic [31:0] lat_old;

  assign op_e         = op_t'(op);
  assign fault        = access_fault(op_e, addr, ADDR_LIMIT);
  assign is_load      = (op_e == OP_LW) || (op_e == OP_LH) || (op_e == OP_LHU) ||
                        (op_e == OP_LB) || (op_e == OP_LBU);
  assign is_sub_store = (op_e == OP_SH) || (op_e == OP_SB);
  assign accept       = !reset && (state == ST_IDLE) && req_valid && !fault;

  load_extender u_load_extender (
    .word (dm_rd),
    .lane (addr[1:0]),
    .op   (op_e),
    .data (load_data)
  );

  // Old word with the latched lane overwritten by the store data.
  always_comb begin
    merged = lat_old;
    if (lat_is_half)
      merged[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
    else
      merged[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
  end

  always_comb begin
    dm_addr = {addr[31:2], 2'b00};
    dm_wd   = wdata;
    dm_pc   = pc;
    dm_we   = 1'b0;
    stall   = 1'b0;
    rdata   = 32'h0;
    if (state == ST_RMW_WR) begin
      // Inputs are ignored here; the instruction retires with this write.
      // A reset landing in this cycle kills the write.
      dm_addr = {lat_word, 2'b00};
      dm_wd   = merged;
      dm_pc   = lat_pc;
      dm_we   = !reset;
    end else if (accept) begin
      if (is_load)
        rdata = load_data;
      if (op_e == OP_SW)
        dm_we = 1'b1;
      if (is_sub_store)
        stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      err         <= 1'b0;
      lat_word    <= '0;
      lat_lane    <= '0;
      lat_is_half <= 1'b0;
      lat_wdata   <= '0;
      lat_pc      <= '0;
      lat_old     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && fault) begin
            err <= 1'b1;
          end else if (accept && is_sub_store) begin
            lat_word    <= addr[31:2];
            lat_lane    <= addr[1:0];
            lat_is_half <= (op_e == OP_SH);
            lat_wdata   <= wdata[15:0];
            lat_pc      <= pc;
            lat_old     <= dm_rd;
            state       <= ST_RMW_WR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
